// File: rtl/hilo_mul_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply sequencer.
//   state_e      : FSM encoding (idle / iterating / writing product)
//   REGTOMUL_*   : ex_regToMul decodes for MTHI / MTLO
//   DATA_W       : architectural register width
//   abs32        : magnitude of a two's complement word, as an unsigned value
package hilo_mul_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] REGTOMUL_HI = 2'b01;
    localparam logic [1:0] REGTOMUL_LO = 2'b10;

    // |0x80000000| wraps back to 0x80000000, which is correct when read as unsigned.
    function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Iterative shift-add multiplier datapath.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture operands (magnitudes when sgn_i), clear accumulator and counter
//   step_i        : retire BITS_PER_CYCLE multiplier bits
//   a_i, b_i      : multiplicand, multiplier
//   sgn_i         : 1 = signed multiply
//   last_o        : the current step is the final one
//   product_o     : sign-corrected 64-bit product
module mul_iter_core
    import hilo_mul_ctrl_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic                  sgn_i,
    output logic                  last_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int unsigned ITER = DATA_W / BITS_PER_CYCLE;

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                neg_q, neg_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        if (load_i) begin
            mcand_d  = {32'd0, (sgn_i ? abs32(a_i) : a_i)};
            mplier_d = sgn_i ? abs32(b_i) : b_i;
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = sgn_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
        end else if (step_i) begin
            for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
                if (mplier_q[k]) begin
                    acc_d = acc_d + (mcand_q << k);
                end
            end
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign last_o    = (cnt_q == 6'(ITER - 1));
    assign product_o = neg_q ? (~acc_q + 64'd1) : acc_q;

endmodule

// File: rtl/hilo_mul_ctrl.sv
// HI/LO register pair and multiply sequencer for the EX/MEM stage.
//   Clk, Rst_n              : clock, asynchronous active-low reset
//   ex_mulStart/ex_mulSigned: MULT (signed) / MULTU request
//   ex_busA, ex_busB        : operands; ex_busA also sources MTHI/MTLO
//   ex_regToMul             : 01 = MTHI, 10 = MTLO, else none
//   ex_mulRead, ex_mulToReg : MFHI (1) / MFLO (0) read
//   flush                   : exception flush
//   mul_stall               : pipeline hold while a HI/LO user meets a busy unit
//   mul_busy, mul_done      : unit busy; product-write pulse
//   mul_rdata, hi, lo       : read data and raw registers
module hilo_mul_ctrl
    import hilo_mul_ctrl_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ex_mulStart,
    input  logic              ex_mulSigned,
    input  logic [DATA_W-1:0] ex_busA,
    input  logic [DATA_W-1:0] ex_busB,
    input  logic [1:0]        ex_regToMul,
    input  logic              ex_mulRead,
    input  logic              ex_mulToReg,
    input  logic              flush,
    output logic              mul_stall,
    output logic              mul_busy,
    output logic              mul_done,
    output logic [DATA_W-1:0] mul_rdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                core_load, core_step, core_last;
    logic [2*DATA_W-1:0] core_product;

    mul_iter_core #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk_i     (Clk),
        .rst_ni    (Rst_n),
        .load_i    (core_load),
        .step_i    (core_step),
        .a_i       (ex_busA),
        .b_i       (ex_busB),
        .sgn_i     (ex_mulSigned),
        .last_o    (core_last),
        .product_o (core_product)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = 1'b0;
        core_step = 1'b0;
        mul_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    if (ex_mulStart) begin
                        core_load = 1'b1;
                        state_d   = S_CALC;
                    end else if (ex_regToMul == REGTOMUL_HI) begin
                        hi_d = ex_busA;
                    end else if (ex_regToMul == REGTOMUL_LO) begin
                        lo_d = ex_busA;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The multiply is older than any faulting instruction, so flush is ignored.
                {hi_d, lo_d} = core_product;
                mul_done     = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        mul_busy  = (state_q != S_IDLE);
        // Stall stays up through DONE so a trailing read sees the new HI/LO in IDLE.
        mul_stall = !flush && mul_busy &&
                    (ex_mulStart || ex_mulRead || (ex_regToMul != 2'b00));
        mul_rdata = ex_mulToReg ? hi_q : lo_q;
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
module tb_hilo_mul_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic        ex_mulStart;
    logic        ex_mulSigned;
    logic [31:0] ex_busA;
    logic [31:0] ex_busB;
    logic [1:0]  ex_regToMul;
    logic        ex_mulRead;
    logic        ex_mulToReg;
    logic        flush;

    logic        d1_stall, d1_busy, d1_done;
    logic [31:0] d1_rdata, d1_hi, d1_lo;
    logic        d2_stall, d2_busy, d2_done;
    logic [31:0] d2_rdata, d2_hi, d2_lo;
    logic        d4_stall, d4_busy, d4_done;
    logic [31:0] d4_rdata, d4_hi, d4_lo;

    int n_cmp = 0;
    int n_err = 0;

    hilo_mul_ctrl #(.BITS_PER_CYCLE(1)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .ex_mulStart(ex_mulStart), .ex_mulSigned(ex_mulSigned),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_regToMul(ex_regToMul),
        .ex_mulRead(ex_mulRead), .ex_mulToReg(ex_mulToReg), .flush(flush),
        .mul_stall(d1_stall), .mul_busy(d1_busy), .mul_done(d1_done),
        .mul_rdata(d1_rdata), .hi(d1_hi), .lo(d1_lo)
    );

    hilo_mul_ctrl #(.BITS_PER_CYCLE(2)) u_dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .ex_mulStart(ex_mulStart), .ex_mulSigned(ex_mulSigned),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_regToMul(ex_regToMul),
        .ex_mulRead(ex_mulRead), .ex_mulToReg(ex_mulToReg), .flush(flush),
        .mul_stall(d2_stall), .mul_busy(d2_busy), .mul_done(d2_done),
        .mul_rdata(d2_rdata), .hi(d2_hi), .lo(d2_lo)
    );

    hilo_mul_ctrl #(.BITS_PER_CYCLE(4)) u_dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .ex_mulStart(ex_mulStart), .ex_mulSigned(ex_mulSigned),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_regToMul(ex_regToMul),
        .ex_mulRead(ex_mulRead), .ex_mulToReg(ex_mulToReg), .flush(flush),
        .mul_stall(d4_stall), .mul_busy(d4_busy), .mul_done(d4_done),
        .mul_rdata(d4_rdata), .hi(d4_hi), .lo(d4_lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        ex_mulStart  = 1'b0;
        ex_mulSigned = 1'b0;
        ex_busA      = '0;
        ex_busB      = '0;
        ex_regToMul  = 2'b00;
        ex_mulRead   = 1'b0;
        ex_mulToReg  = 1'b0;
        flush        = 1'b0;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic issue_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        ex_mulStart  = 1'b1;
        ex_mulSigned = sgn;
        ex_busA      = a;
        ex_busB      = b;
        tick();
        ex_mulStart  = 1'b0;
        ex_mulSigned = 1'b0;
        ex_busA      = '0;
        ex_busB      = '0;
    endtask

    // Edges counted from the one that captured the start; returns inside the DONE cycle.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!d1_done && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        Rst_n = 1'b1;
        @(negedge Clk);
        Rst_n = 1'b0;
        ex_mulStart = 1'b1;
        #2;
        n_cmp++; if (d1_hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", d1_hi, 32'h0); end
        n_cmp++; if (d1_lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", d1_lo, 32'h0); end
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", d1_busy); end
        n_cmp++; if (d1_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", d1_done); end
        n_cmp++; if (d1_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", d1_stall); end
        tick();
        tick();
        clear_inputs();
        Rst_n = 1'b1;
        tick();
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", d1_busy); end
    endtask

    task automatic test_signed_corner();
        int e;
        issue_mul(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done(e);
        n_cmp++; if (e !== 33) begin n_err++; $display("FAIL corner_latency: got %0d want %0d", e, 33); end
        tick();
        n_cmp++; if (d1_hi !== 32'h4000_0000) begin n_err++; $display("FAIL corner_hi: got %h want %h", d1_hi, 32'h4000_0000); end
        n_cmp++; if (d1_lo !== 32'h0) begin n_err++; $display("FAIL corner_lo: got %h want %h", d1_lo, 32'h0); end
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL corner_idle: got %b want 0", d1_busy); end
    endtask

    task automatic test_mixed_sign();
        int e;
        issue_mul(1'b1, 32'hFFFF_FFFF, 32'd3);
        wait_done(e);
        tick();
        n_cmp++; if (d1_hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_neg_hi: got %h want %h", d1_hi, 32'hFFFF_FFFF); end
        n_cmp++; if (d1_lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mult_neg_lo: got %h want %h", d1_lo, 32'hFFFF_FFFD); end
        issue_mul(1'b0, 32'hFFFF_FFFF, 32'd3);
        wait_done(e);
        tick();
        n_cmp++; if (d1_hi !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h want %h", d1_hi, 32'h2); end
        n_cmp++; if (d1_lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL multu_lo: got %h want %h", d1_lo, 32'hFFFF_FFFD); end
    endtask

    task automatic test_interlock();
        int   cycles;
        int   bad;
        logic done_stall;
        int   e;
        issue_mul(1'b1, 32'd7, 32'd6);
        ex_mulRead  = 1'b1;
        ex_mulToReg = 1'b0;
        cycles      = 0;
        bad         = 0;
        done_stall  = 1'b0;
        while (d1_busy && cycles < 200) begin
            if (!d1_stall) bad++;
            if (d1_done) done_stall = d1_stall;
            cycles++;
            tick();
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_gaps: got %0d want 0", bad); end
        n_cmp++; if (cycles !== 33) begin n_err++; $display("FAIL stall_cycles: got %0d want %0d", cycles, 33); end
        n_cmp++; if (done_stall !== 1'b1) begin n_err++; $display("FAIL stall_in_done: got %b want 1", done_stall); end
        n_cmp++; if (d1_stall !== 1'b0) begin n_err++; $display("FAIL mflo_idle_stall: got %b want 0", d1_stall); end
        n_cmp++; if (d1_rdata !== 32'h0000_002A) begin n_err++; $display("FAIL mflo_rdata: got %h want %h", d1_rdata, 32'h2A); end
        tick();
        clear_inputs();
        // Unrelated instruction while the unit is busy
        issue_mul(1'b0, 32'd5, 32'd5);
        tick();
        n_cmp++; if (d1_busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b want 1", d1_busy); end
        n_cmp++; if (d1_stall !== 1'b0) begin n_err++; $display("FAIL add_no_stall: got %b want 0", d1_stall); end
        wait_done(e);
        tick();
        n_cmp++; if (d1_lo !== 32'd25) begin n_err++; $display("FAIL add_mul_lo: got %h want %h", d1_lo, 32'd25); end
    endtask

    task automatic test_mthi_mfhi();
        ex_regToMul = 2'b01;
        ex_busA     = 32'h1234_5678;
        n_cmp++; if (d1_stall !== 1'b0) begin n_err++; $display("FAIL mthi_stall: got %b want 0", d1_stall); end
        tick();
        clear_inputs();
        n_cmp++; if (d1_hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h want %h", d1_hi, 32'h1234_5678); end
        ex_mulRead  = 1'b1;
        ex_mulToReg = 1'b1;
        #1;
        n_cmp++; if (d1_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL mfhi_rdata: got %h want %h", d1_rdata, 32'h1234_5678); end
        clear_inputs();
    endtask

    task automatic test_flush();
        int e;
        int seen;
        issue_mul(1'b1, 32'd2, 32'd2);
        repeat (9) tick();
        flush      = 1'b1;
        ex_mulRead = 1'b1;
        #1;
        n_cmp++; if (d1_stall !== 1'b0) begin n_err++; $display("FAIL flush_forces_no_stall: got %b want 0", d1_stall); end
        tick();
        clear_inputs();
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL flush_abort_idle: got %b want 0", d1_busy); end
        n_cmp++; if (d1_hi !== 32'h1234_5678) begin n_err++; $display("FAIL flush_abort_hi: got %h want %h", d1_hi, 32'h1234_5678); end
        n_cmp++; if (d1_lo !== 32'd25) begin n_err++; $display("FAIL flush_abort_lo: got %h want %h", d1_lo, 32'd25); end
        seen = 0;
        repeat (40) begin
            if (d1_done) seen++;
            tick();
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_abort_done: got %0d want 0", seen); end
        // Flush arriving in DONE does not cancel the write
        issue_mul(1'b1, 32'd2, 32'd2);
        wait_done(e);
        flush = 1'b1;
        tick();
        clear_inputs();
        n_cmp++; if (d1_lo !== 32'd4) begin n_err++; $display("FAIL flush_done_lo: got %h want %h", d1_lo, 32'd4); end
        n_cmp++; if (d1_hi !== 32'd0) begin n_err++; $display("FAIL flush_done_hi: got %h want %h", d1_hi, 32'd0); end
        // Flush in IDLE suppresses MTLO and start
        flush       = 1'b1;
        ex_regToMul = 2'b10;
        ex_busA     = 32'hAAAA_5555;
        tick();
        n_cmp++; if (d1_lo !== 32'd4) begin n_err++; $display("FAIL flush_idle_mtlo: got %h want %h", d1_lo, 32'd4); end
        ex_regToMul = 2'b00;
        ex_mulStart = 1'b1;
        tick();
        clear_inputs();
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_start: got %b want 0", d1_busy); end
        // 2'b11 writes nothing
        ex_regToMul = 2'b11;
        ex_busA     = 32'h0000_0055;
        tick();
        clear_inputs();
        n_cmp++; if (d1_hi !== 32'd0) begin n_err++; $display("FAIL regtomul11_hi: got %h want %h", d1_hi, 32'd0); end
        n_cmp++; if (d1_lo !== 32'd4) begin n_err++; $display("FAIL regtomul11_lo: got %h want %h", d1_lo, 32'd4); end
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        ex_regToMul = 2'b01;
        ex_busA     = 32'hCAFE_F00D;
        tick();
        clear_inputs();
        issue_mul(1'b1, 32'd7, 32'd6);
        repeat (4) tick();
        Rst_n = 1'b0;
        #1;
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", d1_busy); end
        n_cmp++; if (d1_hi !== 32'd0) begin n_err++; $display("FAIL midreset_hi: got %h want %h", d1_hi, 32'd0); end
        n_cmp++; if (d1_lo !== 32'd0) begin n_err++; $display("FAIL midreset_lo: got %h want %h", d1_lo, 32'd0); end
        n_cmp++; if (d1_done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", d1_done); end
        @(negedge Clk);
        Rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            if (d1_done || d1_busy) seen++;
            tick();
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midreset_discard: got %0d want 0", seen); end
    endtask

    task automatic test_param_sweep();
        int edges;
        int e1;
        int e2;
        int e4;
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        @(negedge Clk);
        Rst_n = 1'b1;
        issue_mul(1'b0, 32'hDEAD_BEEF, 32'h0123_4567);
        edges = 1;
        e1    = 0;
        e2    = 0;
        e4    = 0;
        while (edges < 40) begin
            if (d1_done && e1 == 0) e1 = edges;
            if (d2_done && e2 == 0) e2 = edges;
            if (d4_done && e4 == 0) e4 = edges;
            tick();
            edges++;
        end
        n_cmp++; if (e1 !== 33) begin n_err++; $display("FAIL sweep_lat_b1: got %0d want %0d", e1, 33); end
        n_cmp++; if (e2 !== 17) begin n_err++; $display("FAIL sweep_lat_b2: got %0d want %0d", e2, 17); end
        n_cmp++; if (e4 !== 9) begin n_err++; $display("FAIL sweep_lat_b4: got %0d want %0d", e4, 9); end
        // 0xDEADBEEF * 0x01234567 = 0x00FD5BDE_760B3D29
        n_cmp++; if ({d1_hi, d1_lo} !== 64'h00FD5BDE_760B3D29) begin n_err++; $display("FAIL sweep_prod_b1: got %h want %h", {d1_hi, d1_lo}, 64'h00FD5BDE_760B3D29); end
        n_cmp++; if ({d2_hi, d2_lo} !== 64'h00FD5BDE_760B3D29) begin n_err++; $display("FAIL sweep_prod_b2: got %h want %h", {d2_hi, d2_lo}, 64'h00FD5BDE_760B3D29); end
        n_cmp++; if ({d4_hi, d4_lo} !== 64'h00FD5BDE_760B3D29) begin n_err++; $display("FAIL sweep_prod_b4: got %h want %h", {d4_hi, d4_lo}, 64'h00FD5BDE_760B3D29); end
        n_cmp++; if (d2_busy !== 1'b0 || d4_busy !== 1'b0) begin n_err++; $display("FAIL sweep_idle: got %b%b want 00", d2_busy, d4_busy); end
    endtask

    initial begin
        test_reset();
        test_signed_corner();
        test_mixed_sign();
        test_interlock();
        test_mthi_mfhi();
        test_flush();
        test_reset_mid_calc();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
